// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch: FSM state encoding, the BCD digit
// ceiling and a helper that sizes the prescaler register.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Width of a counter that must hold 0..div-1; never narrower than one bit.
  function automatic int presc_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the stopwatch. Increments 0..9 when inc_in is high and
// raises a combinational carry so a chain of these ripples in one edge.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc_in,
  output logic       carry_out,
  output logic [3:0] q
);

  logic [3:0] r_q;

  assign carry_out = inc_in && (r_q == BCD_MAX);
  assign q         = r_q;

  // Digit register: clear to zero, otherwise step 0..9 with rollover.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled inside the clocked block, so it is synchronous
    // and takes effect only on a rising edge.
    if (reset || clr) begin
      // NOTE: non-blocking assignments so every flop in the design samples
      // the pre-edge values and updates together.
      r_q <= '0;
    end else if (inc_in) begin
      r_q <= carry_out ? '0 : r_q + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch timebase and 4-digit BCD counter (SS.hh). A prescaler divides the
// system clock down to the count rate; a small FSM gates it with start/pause
// and clear; four chained BCD digits hold the displayed value.
module stopwatch_bcd_counter
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100,
  parameter bit WRAP    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic       running,
  output logic       tick,
  output logic       wrap
);

  // Clock cycles per count step; the design assumes this is at least 2.
  localparam int             DIV        = CLK_HZ / TICK_HZ;
  localparam int             PW         = presc_width(DIV);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_next;
  logic          r_running;
  logic          r_tick;
  logic          r_wrap;

  logic [3:0]    w_q [4];
  logic [4:0]    w_chain;      // w_chain[i] increments digit i; [4] is carry out of 99.99
  logic          w_presc_last;
  logic          w_at_max;
  logic          w_one_below;
  logic          w_held;
  logic          w_inc;
  logic          w_reach_hold;

  assign w_presc_last = (r_state == ST_RUN) && (r_presc == PRESC_LAST);

  assign w_at_max    = (w_q[3] == BCD_MAX) && (w_q[2] == BCD_MAX) &&
                       (w_q[1] == BCD_MAX) && (w_q[0] == BCD_MAX);
  assign w_one_below = (w_q[3] == BCD_MAX) && (w_q[2] == BCD_MAX) &&
                       (w_q[1] == BCD_MAX) && (w_q[0] == BCD_MAX - 4'd1);

  // In hold mode the count sticks at 99.99; no further increments happen.
  assign w_held       = !WRAP && w_at_max;
  // clear beats an increment that would otherwise land on the same edge.
  assign w_inc        = w_presc_last && !clear && !w_held;
  assign w_reach_hold = !WRAP && w_inc && w_one_below;

  assign w_chain[0] = w_inc;

  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    bcd_digit u_digit (
      .clk       (clk),
      .reset     (reset),
      .clr       (clear),
      .inc_in    (w_chain[gi]),
      .carry_out (w_chain[gi+1]),
      .q         (w_q[gi])
    );
  end

  // Next-state and prescaler logic for IDLE / RUN / PAUSE.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_state_next = r_state;
    w_presc_next = r_presc;
    unique case (r_state)
      ST_IDLE: begin
        w_presc_next = '0;
        if (start_stop) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_held) begin
          // Resumed while held at 99.99: fall straight back to PAUSE.
          w_state_next = ST_PAUSE;
        end else begin
          w_presc_next = w_presc_last ? '0 : r_presc + 1'b1;
          // A pause on the terminal prescaler cycle still lets the step land.
          if (start_stop || w_reach_hold) w_state_next = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (start_stop) w_state_next = ST_RUN;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_presc_next = '0;
      end
    endcase
    if (clear) begin
      w_state_next = ST_IDLE;
      w_presc_next = '0;
    end
  end

  // State and prescaler registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_presc <= '0;
    end else begin
      r_state <= w_state_next;
      r_presc <= w_presc_next;
    end
  end

  // Status pulses, registered so they line up with the updated digits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_running <= 1'b0;
      r_tick    <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_running <= (w_state_next == ST_RUN);
      r_tick    <= w_inc;
      r_wrap    <= WRAP ? w_chain[4] : w_reach_hold;
    end
  end

  assign d0      = w_q[0];
  assign d1      = w_q[1];
  assign d2      = w_q[2];
  assign d3      = w_q[3];
  assign running = r_running;
  assign tick    = r_tick;
  assign wrap    = r_wrap;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Bench for stopwatch_bcd_counter. The main instance runs at DIV=10; a pair
// of DIV=2 instances (wrap and hold variants, shared inputs) reaches the long
// counts (12.34, 37.89, 99.99) in a reasonable number of cycles. Stimulus
// pushes expected tick events into queues; monitors pop them on every tick.
module tb_stopwatch_bcd_counter;

  typedef struct {
    int          cyc;
    logic [15:0] digits;
    logic        wrap;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  exp_t q_main[$];
  exp_t q_fast[$];
  exp_t m_e, f_e;

  // ---------------- main instance: DIV = 10, wrapping ----------------
  logic       reset = 1'b1, start_stop = 1'b0, clear = 1'b0;
  logic [3:0] m_d0, m_d1, m_d2, m_d3;
  logic       m_running, m_tick, m_wrap;
  logic [15:0] m_digits;
  assign m_digits = {m_d3, m_d2, m_d1, m_d0};

  stopwatch_bcd_counter #(.CLK_HZ(1000), .TICK_HZ(100), .WRAP(1'b1)) dut (
    .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear),
    .d0(m_d0), .d1(m_d1), .d2(m_d2), .d3(m_d3),
    .running(m_running), .tick(m_tick), .wrap(m_wrap)
  );

  // ---------------- fast pair: DIV = 2, wrap (f1) and hold (f0) ----------------
  logic       f_reset = 1'b1, f_ss = 1'b0, f_clr = 1'b0;
  logic [3:0] f1_d0, f1_d1, f1_d2, f1_d3, f0_d0, f0_d1, f0_d2, f0_d3;
  logic       f1_running, f1_tick, f1_wrap, f0_running, f0_tick, f0_wrap;
  logic [15:0] f1_digits, f0_digits;
  assign f1_digits = {f1_d3, f1_d2, f1_d1, f1_d0};
  assign f0_digits = {f0_d3, f0_d2, f0_d1, f0_d0};

  stopwatch_bcd_counter #(.CLK_HZ(200), .TICK_HZ(100), .WRAP(1'b1)) dut_f1 (
    .clk(clk), .reset(f_reset), .start_stop(f_ss), .clear(f_clr),
    .d0(f1_d0), .d1(f1_d1), .d2(f1_d2), .d3(f1_d3),
    .running(f1_running), .tick(f1_tick), .wrap(f1_wrap)
  );

  stopwatch_bcd_counter #(.CLK_HZ(200), .TICK_HZ(100), .WRAP(1'b0)) dut_f0 (
    .clk(clk), .reset(f_reset), .start_stop(f_ss), .clear(f_clr),
    .d0(f0_d0), .d1(f0_d1), .d2(f0_d2), .d3(f0_d3),
    .running(f0_running), .tick(f0_tick), .wrap(f0_wrap)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Expect n consecutive increments, the first at edge c0 reaching value v0.
  function automatic void push_run(input bit fast, input int c0, input int v0,
                                   input int n, input int period);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.cyc    = c0 + i * period;
      e.wrap   = ((v0 + i) == 10000);
      e.digits = to_bcd((v0 + i) % 10000);
      if (fast) q_fast.push_back(e);
      else      q_main.push_back(e);
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- monitors ----------------
  int   main_ticks = 0;
  int   f0_ticks   = 0;
  logic m_prev_tick = 1'b0, m_prev_wrap = 1'b0;
  logic f_prev_tick = 1'b0, f_prev_wrap = 1'b0, f0_prev_tick = 1'b0;

  always @(negedge clk) begin
    check("main_digit_range", (m_d0 <= 4'd9) && (m_d1 <= 4'd9) &&
                              (m_d2 <= 4'd9) && (m_d3 <= 4'd9), 1);
    check("main_tick_twice", m_tick && m_prev_tick, 0);
    check("main_wrap_twice", m_wrap && m_prev_wrap, 0);
    if (m_tick === 1'b1) begin
      main_ticks++;
      check("main_tick_expected", q_main.size() != 0, 1);
      if (q_main.size() != 0) begin
        m_e = q_main.pop_front();
        check("main_tick_cycle", cyc, m_e.cyc);
        check("main_tick_digits", m_digits, m_e.digits);
        check("main_tick_wrap", m_wrap, m_e.wrap);
      end
    end else begin
      check("main_wrap_without_tick", m_wrap, 0);
    end
    m_prev_tick = m_tick;
    m_prev_wrap = m_wrap;
  end

  always @(negedge clk) begin
    check("fast_digit_range", (f1_d0 <= 4'd9) && (f1_d1 <= 4'd9) && (f1_d2 <= 4'd9) &&
                              (f1_d3 <= 4'd9) && (f0_d0 <= 4'd9) && (f0_d1 <= 4'd9) &&
                              (f0_d2 <= 4'd9) && (f0_d3 <= 4'd9), 1);
    check("f1_tick_twice", f1_tick && f_prev_tick, 0);
    check("f1_wrap_twice", f1_wrap && f_prev_wrap, 0);
    check("f0_tick_twice", f0_tick && f0_prev_tick, 0);
    if (f0_tick === 1'b1) f0_ticks++;
    if (f1_tick === 1'b1) begin
      check("f1_tick_expected", q_fast.size() != 0, 1);
      if (q_fast.size() != 0) begin
        f_e = q_fast.pop_front();
        check("f1_tick_cycle", cyc, f_e.cyc);
        check("f1_tick_digits", f1_digits, f_e.digits);
        check("f1_tick_wrap", f1_wrap, f_e.wrap);
      end
    end
    f_prev_tick  = f1_tick;
    f_prev_wrap  = f1_wrap;
    f0_prev_tick = f0_tick;
  end

  // ---------------- stimulus ----------------
  int e0, e1, er, ef, ef2, ef3;
  int ms, mp, mc, model_ticks, soak_base;
  bit ss, cl, inc, wr;
  localparam int SOAK_N = 20000;

  initial begin
    // Reset state, with start_stop held high to show reset overrides it.
    start_stop = 1'b1;
    idle(3);
    check("reset_digits", m_digits, 16'h0000);
    check("reset_running", m_running, 0);
    check("reset_tick", m_tick, 0);
    check("reset_wrap", m_wrap, 0);
    check("reset_f_digits", {f1_digits, f0_digits}, 32'h0);
    reset = 1'b0; f_reset = 1'b0; start_stop = 1'b0;
    idle(2);
    check("idle_after_reset_running", m_running, 0);

    // 1) Start: running next edge, 00.01 ten cycles later, 00.10 after 100.
    e0 = cyc + 1;
    start_stop = 1'b1;
    push_run(1'b0, e0 + 10, 1, 10, 10);
    @(negedge clk); start_stop = 1'b0;
    check("t1_running", m_running, 1);
    idle(100);
    check("t1_digits_0p10", m_digits, 16'h0010);
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    check("t1_clear_digits", m_digits, 16'h0000);
    check("t1_clear_running", m_running, 0);

    // 2) Pause at 55 cycles, freeze 200 cycles, resume keeps the partial tick.
    e1 = cyc + 1;
    start_stop = 1'b1;
    push_run(1'b0, e1 + 10, 1, 5, 10);
    @(negedge clk); start_stop = 1'b0;
    idle(54);
    start_stop = 1'b1; @(negedge clk); start_stop = 1'b0;
    check("t2_paused_running", m_running, 0);
    check("t2_paused_digits", m_digits, 16'h0005);
    idle(200);
    check("t2_frozen_digits", m_digits, 16'h0005);
    check("t2_frozen_running", m_running, 0);
    er = cyc + 1;
    start_stop = 1'b1;
    push_run(1'b0, er + 5, 6, 2, 10);
    @(negedge clk); start_stop = 1'b0;
    check("t2_resume_running", m_running, 1);
    idle(15);
    check("t2_digits_0p07", m_digits, 16'h0007);
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    check("t2_clear_digits", m_digits, 16'h0000);

    // 4) At 12.34, start_stop and clear together on a terminal prescaler cycle.
    ef = cyc + 1;
    f_ss = 1'b1;
    push_run(1'b1, ef + 2, 1, 1234, 2);
    @(negedge clk); f_ss = 1'b0;
    idle(2468);
    check("t4_at_12p34", f1_digits, 16'h1234);
    check("t4_tick_on_12p34", f1_tick, 1);
    idle(1);
    f_ss = 1'b1; f_clr = 1'b1;
    @(negedge clk); f_ss = 1'b0; f_clr = 1'b0;
    check("t4_clear_digits", f1_digits, 16'h0000);
    check("t4_clear_running", f1_running, 0);
    check("t4_clear_no_tick", f1_tick, 0);
    check("t4_clear_f0_digits", f0_digits, 16'h0000);
    idle(4);
    check("t4_stays_idle", {f1_running, f1_digits}, 17'h0);

    // 5) Reset at 37.89 with the prescaler on its last count.
    ef2 = cyc + 1;
    f_ss = 1'b1;
    push_run(1'b1, ef2 + 2, 1, 3789, 2);
    @(negedge clk); f_ss = 1'b0;
    idle(7578);
    check("t5_at_37p89", f1_digits, 16'h3789);
    idle(1);
    f_reset = 1'b1; f_ss = 1'b1;
    @(negedge clk); f_reset = 1'b0; f_ss = 1'b0;
    check("t5_reset_digits", f1_digits, 16'h0000);
    check("t5_reset_flags", {f1_running, f1_tick, f1_wrap}, 3'b000);
    check("t5_reset_f0", {f0_running, f0_tick, f0_wrap, f0_digits}, 19'h0);
    idle(5);
    check("t5_idle_after_reset", {f1_running, f1_digits}, 17'h0);

    // 3) Run to 99.99: f1 wraps to 00.00 and keeps going, f0 holds and stops.
    ef3 = cyc + 1;
    f_ss = 1'b1;
    push_run(1'b1, ef3 + 2, 1, 10001, 2);
    @(negedge clk); f_ss = 1'b0;
    idle(19998);
    check("t3_f0_reach_digits", f0_digits, 16'h9999);
    check("t3_f0_reach_wrap", f0_wrap, 1);
    check("t3_f0_reach_tick", f0_tick, 1);
    check("t3_f0_reach_running", f0_running, 0);
    check("t3_f1_at_max", f1_digits, 16'h9999);
    check("t3_f1_running", f1_running, 1);
    idle(2);
    check("t3_f1_wrapped", f1_digits, 16'h0000);
    check("t3_f1_wrap_pulse", f1_wrap, 1);
    check("t3_f1_still_running", f1_running, 1);
    check("t3_f0_held", f0_digits, 16'h9999);
    check("t3_f0_no_tick", {f0_tick, f0_wrap}, 2'b00);
    idle(1);
    check("t3_f1_wrap_gone", f1_wrap, 0);
    f_ss = 1'b1; @(negedge clk); f_ss = 1'b0;
    check("t3_f0_resume_running", f0_running, 1);
    check("t3_f1_pause_step", f1_digits, 16'h0001);
    check("t3_f1_paused", f1_running, 0);
    idle(1);
    check("t3_f0_falls_back", f0_running, 0);
    check("t3_f0_still_held", f0_digits, 16'h9999);
    idle(10);
    check("t3_final_digits", {f1_digits, f0_digits}, 32'h0001_9999);

    // 6) Random pulse soak on the main instance against a reference model.
    ms = 0; mp = 0; mc = 0; model_ticks = 0;
    soak_base = main_ticks;
    for (int i = 0; i < SOAK_N; i++) begin
      ss = ($urandom_range(0, 99) < 4);
      cl = (i == SOAK_N - 1) || ($urandom_range(0, 299) == 0);
      start_stop = ss; clear = cl;
      inc = (ms == 1) && (mp == 9) && !cl;
      if (cl) begin
        ms = 0; mp = 0; mc = 0;
      end else begin
        if (ms == 1) mp = (mp == 9) ? 0 : mp + 1;
        if (inc) begin
          mc = mc + 1;
          wr = (mc == 10000);
          if (wr) mc = 0;
          q_main.push_back('{cyc: cyc + 1, digits: to_bcd(mc), wrap: wr});
          model_ticks++;
        end
        if (ss) ms = (ms == 1) ? 2 : 1;
      end
      @(negedge clk);
      check("soak_running", m_running, (ms == 1));
    end
    start_stop = 1'b0; clear = 1'b0;
    idle(5);

    check("main_queue_drained", q_main.size(), 0);
    check("fast_queue_drained", q_fast.size(), 0);
    check("soak_tick_count", main_ticks - soak_base, model_ticks);
    check("f0_tick_count", f0_ticks, 1234 + 3789 + 9999);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
